// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO and its write-side arbiter.
// Contents: default width constants, arbiter state enum, clog2 helper.
package fifo_pkg;

    localparam int unsigned default_address_bus_length = 4;
    localparam int unsigned default_data_bus_length    = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Ceiling log2 with a floor of 1 so single-bit indices never collapse to zero width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO write-side bundle for fifo_write_arbiter.
// master (arbiter): in  req, req_data, fifo_full
//                   out ack, write_enable, trans_data, owner, busy
// slave  (environment): the mirror image.
interface fifo_write_arbiter_if
    import fifo_pkg::*;
#(
    parameter int unsigned num_req = 4,
    parameter int unsigned data_w  = default_data_bus_length
) ();

    localparam int unsigned idx_w = clog2(num_req);

    logic [num_req-1:0]        req;
    logic [num_req*data_w-1:0] req_data;
    logic [num_req-1:0]        ack;
    logic                      fifo_full;
    logic                      write_enable;
    logic [data_w-1:0]         trans_data;
    logic [idx_w-1:0]          owner;
    logic                      busy;

    modport master (
        input  req, req_data, fifo_full,
        output ack, write_enable, trans_data, owner, busy
    );

    modport slave (
        output req, req_data, fifo_full,
        input  ack, write_enable, trans_data, owner, busy
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// req_i   : request vector
// ptr_i   : index with highest priority this cycle
// idx_o   : first set index at or after ptr_i (wrapping)
// found_o : any request set
module rr_pick
    import fifo_pkg::*;
#(
    parameter  int unsigned num_req = 4,
    localparam int unsigned idx_w   = clog2(num_req)
) (
    input  logic [num_req-1:0] req_i,
    input  logic [idx_w-1:0]   ptr_i,
    output logic [idx_w-1:0]   idx_o,
    output logic               found_o
);

    // Walk offsets 0..num_req-1 from the pointer; first hit wins.
    always_comb begin
        int unsigned cand;
        idx_o   = '0;
        found_o = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < num_req; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= num_req) begin
                cand = cand - num_req;
            end
            for (int unsigned j = 0; j < num_req; j++) begin
                if (!found_o && (j == cand) && req_i[j]) begin
                    found_o = 1'b1;
                    idx_o   = idx_w'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the asynchronous FIFO's single write port
// between num_req requesters, with a max_burst cap per grant.
// trans_clk : transmit-domain clock
// trans_rst : asynchronous active-low reset
// bus       : master modport (req/req_data/fifo_full in;
//             ack/write_enable/trans_data/owner/busy out)
// The write path (write_enable, ack, trans_data) is combinational from
// registered state so a word is consumed in the cycle its ack is seen.
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned num_req         = 4,
    parameter int unsigned data_bus_length = fifo_pkg::default_data_bus_length,
    parameter int unsigned max_burst       = 4
) (
    input  logic                 trans_clk,
    input  logic                 trans_rst,
    fifo_write_arbiter_if.master bus
);

    localparam int unsigned idx_w   = clog2(num_req);
    localparam int unsigned burst_w = 4;

    arb_state_t         state_q, state_d;
    logic [idx_w-1:0]   ptr_q, ptr_d;
    logic [idx_w-1:0]   owner_q, owner_d;
    logic [burst_w-1:0] burst_q, burst_d;

    logic [data_bus_length-1:0] words [num_req];
    logic [idx_w-1:0]   ptr_exit;
    logic [idx_w-1:0]   idle_idx, exit_idx;
    logic               idle_found, exit_found;
    logic [burst_w-1:0] burst_inc;
    logic               owner_req, grant_active, we, rotate;

    // Unflatten requester data slices.
    always_comb begin
        for (int unsigned i = 0; i < num_req; i++) begin
            words[i] = bus.req_data[i*data_bus_length +: data_bus_length];
        end
    end

    assign owner_req    = bus.req[owner_q];
    assign grant_active = (state_q == GRANT);
    assign we           = grant_active & owner_req & ~bus.fifo_full;

    // Write path.
    always_comb begin
        bus.ack          = '0;
        bus.ack[owner_q] = we;
    end

    assign bus.write_enable = we;
    assign bus.trans_data   = we ? words[owner_q] : '0;
    assign bus.owner        = owner_q;
    assign bus.busy         = grant_active;

    // Pointer used after leaving a grant: one past the current owner.
    assign ptr_exit  = (owner_q == idx_w'(num_req - 1)) ? '0 : owner_q + idx_w'(1);
    assign burst_inc = burst_q + burst_w'(1);

    // Full stalls keep we low, so only a completed burst or a withdrawn request rotates.
    assign rotate = (we && (burst_inc == burst_w'(max_burst))) || !owner_req;

    rr_pick #(.num_req(num_req)) u_pick_idle (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .idx_o   (idle_idx),
        .found_o (idle_found)
    );

    rr_pick #(.num_req(num_req)) u_pick_exit (
        .req_i   (bus.req),
        .ptr_i   (ptr_exit),
        .idx_o   (exit_idx),
        .found_o (exit_found)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        unique case (state_q)
            IDLE: begin
                if (idle_found) begin
                    state_d = GRANT;
                    owner_d = idle_idx;
                    burst_d = '0;
                end
            end
            GRANT: begin
                if (rotate) begin
                    ptr_d   = ptr_exit;
                    burst_d = '0;
                    if (exit_found) begin
                        owner_d = exit_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (we) begin
                    burst_d = burst_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge trans_clk or negedge trans_rst) begin
        if (!trans_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of asynchronous_fifo between several requesters, all in the transmit clock domain.
- Arbitration is round-robin with bounded burst hold-off. It honours fifo_full and drives write_enable and trans_data for the FIFO directly.
- Sits between the requester blocks and the FIFO's transmit side. Clocking is unchanged; all logic runs on trans_clk.

Parameters:
- num_req, 4, number of requesters (2..8).
- data_bus_length, 8, data width; must match the FIFO data_bus_length.
- max_burst, 4, maximum consecutive accepted words per grant before rotation (1..15).

Ports:
- trans_clk  input  1  transmit-domain clock; all state updates on rising edge.
- trans_rst  input  1  asynchronous active-low reset.
- req  input  num_req  req[i] high means requester i has a valid word on its req_data slice.
- req_data  input  num_req*data_bus_length  flattened data; slice i is bits [i*data_bus_length +: data_bus_length].
- ack  output  num_req  one-hot; ack[i] high means requester i's word is written this cycle.
- fifo_full  input  1  full flag from the FIFO, transmit domain.
- write_enable  output  1  FIFO write strobe.
- trans_data  output  data_bus_length  FIFO write data.
- owner  output  clog2(num_req)  index of the current grant holder; valid when busy is high.
- busy  output  1  high in GRANT state.

Behaviour:
- Reset (trans_rst low, asynchronous):
  - state=IDLE, priority pointer=0, burst count=0, owner=0, busy=0.
  - ack=0, write_enable=0, trans_data=0.
  - Reset deasserts synchronously with respect to trans_clk.
- Write path is combinational from registered state:
  - write_enable = busy & req[owner] & ~fifo_full.
  - ack[owner] = write_enable; all other ack bits are 0.
  - trans_data = req_data slice owner when write_enable is high, otherwise 0.
  - Zero-cycle latency: a word is consumed in the same cycle ack is seen.
- Requester rule: req[i] and its slice are held stable until ack[i]. Deasserting req without ack is allowed and withdraws the word; nothing is written.
- IDLE:
  - If any req is high, search round-robin starting at the priority pointer. The first set index is registered as owner; burst count=0; go to GRANT.
  - No write occurs in the IDLE cycle, so there is 1 cycle of arbitration latency.
- GRANT:
  - Each write_enable cycle increments burst count.
  - Leave GRANT at the clock edge where either:
    - burst count reaches max_burst, including the write on that edge; or
    - req[owner] is low.
  - On exit, pointer = owner+1 modulo num_req.
  - If other requests are pending, go directly to the next owner chosen by round-robin from the new pointer. No IDLE bubble; burst count resets to 0.
  - Otherwise go to IDLE.
  - If the only pending requester is the current owner after a max_burst exit, it is re-granted with a fresh burst count.
- fifo_full high in GRANT:
  - write_enable and ack are 0; burst count holds; state holds.
  - The owner keeps the grant while its req stays high. Full stalls never cause rotation.
- Pointer wrap: num_req-1 wraps to 0.
- Simultaneous events:
  - max_burst reached on the same edge that req[owner] drops: a single exit; pointer advances once.
  - fifo_full toggling: sampled combinationally each cycle; no internal history.
- Reset mid-burst: an in-progress burst is abandoned with no write on the reset cycle; pointer returns to 0.
- Fairness: every continuously requesting index receives a grant within (num_req-1) grants, excluding FIFO stalls.

Decomposition:
- Shared package fifo_pkg:
  - state enum {IDLE, GRANT};
  - clog2 helper function;
  - default width constants shared with asynchronous_fifo (address_bus_length, data_bus_length).
- One sub-module: rr_pick.
  - Combinational round-robin priority encoder.
  - Inputs: req vector, pointer. Outputs: index, found.
  - Instantiated twice: from the IDLE pointer and from the exit pointer.

Test Plan:
1. Reset and single requester: reset low 2 cycles. req[2]=1 with words 17..20 presented on ack. Expect owner=2 after 1 IDLE cycle, then 4 consecutive writes 17,18,19,20. ack[2] high each write cycle.
2. Round-robin rotation: req=4'b1111 held, each requester sending 6 words, max_burst=4. Expect grant order 0,1,2,3,0,1,2,3. Bursts of 4 words, then 2. No idle cycle between owners. 24 writes total.
3. Full stall: owner 1 mid-burst after 2 writes; fifo_full=1 for 5 cycles. Expect write_enable=0, ack=0, owner=1 and burst count=2 held throughout. After release, exactly 2 more writes occur before rotation.
4. Early withdraw: req[0] drops after 1 write with req[3] pending. Expect exit on that edge, pointer=1, owner=3 next cycle.
5. Reset mid-burst: assert trans_rst low during owner 2's third write cycle. Expect write_enable, ack and busy=0 immediately. After release with req=4'b0110, first owner is 1 (pointer=0).
6. Integration: drive the FIFO DUT with write clock 40 ns and read clock 100 ns, 3 requesters × 16 words, continuous reads. Expect no write while fifo_full. All 48 words read out, and per-requester order is preserved.
